// File: rtl/lpc_levinson_durbin.sv
// Order-3 Levinson-Durbin solver: turns one block of ACF lags into fixed-point
// predictor coefficients and the final prediction error, using one shared serial divider.
module lpc_levinson_durbin #(
  parameter int FRAC_BITS = 14,
  parameter int COEF_W    = 18,
  parameter int ACF_W     = 32
) (
  input  logic                     iClock,
  input  logic                     iReset,
  input  logic                     iEnable,
  input  logic                     iValid,
  input  logic signed [ACF_W-1:0]  iACF0,
  input  logic signed [ACF_W-1:0]  iACF1,
  input  logic signed [ACF_W-1:0]  iACF2,
  input  logic signed [ACF_W-1:0]  iACF3,
  output logic                     oBusy,
  output logic                     oValid,
  output logic signed [COEF_W-1:0] oCoef1,
  output logic signed [COEF_W-1:0] oCoef2,
  output logic signed [COEF_W-1:0] oCoef3,
  output logic signed [ACF_W-1:0]  oError
);

  localparam int PROD_W = ACF_W + COEF_W;
  localparam int ACC_W  = PROD_W + 2;
  localparam int REM_W  = ACF_W + 2;
  localparam int KP_W   = 2 * COEF_W;
  localparam int EK_W   = ACC_W + COEF_W;
  localparam int CNT_W  = $clog2(FRAC_BITS + 2) + 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] NUM  = 3'd2;
  localparam logic [2:0] DIV  = 3'd3;
  localparam logic [2:0] UPD  = 3'd4;
  localparam logic [2:0] ERR  = 3'd5;
  localparam logic [2:0] TERM = 3'd6;
  localparam logic [2:0] DONE = 3'd7;

  localparam logic [FRAC_BITS-1:0] KMAX = {FRAC_BITS{1'b1}};
  localparam logic [CNT_W-1:0]     DIV_LAST = CNT_W'(FRAC_BITS + 1);

  logic [2:0]               state_r;
  logic [1:0]               m_r;
  logic [CNT_W-1:0]         cnt_r;
  logic signed [ACF_W-1:0]  r0_r, r1_r, r2_r, r3_r;
  logic signed [COEF_W-1:0] a1_r, a2_r, a3_r;
  logic signed [ACF_W-1:0]  e_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [ACC_W-1:0]  num_r;
  logic signed [COEF_W-1:0] k_r;
  logic                     neg_r;
  logic                     ovf_r;
  logic [REM_W-1:0]         rem_r;
  logic [FRAC_BITS-1:0]     q_r;

  // Clamp a wide signed coefficient into the COEF_W signed range.
  function automatic logic signed [COEF_W-1:0] sat_coef(input logic signed [KP_W-1:0] v);
    logic signed [KP_W-1:0] hi;
    logic signed [KP_W-1:0] lo;
    hi = KP_W'(2 ** (COEF_W - 1) - 1);
    lo = -KP_W'(2 ** (COEF_W - 1));
    if (v > hi) begin
      sat_coef = hi[COEF_W-1:0];
    end else if (v < lo) begin
      sat_coef = lo[COEF_W-1:0];
    end else begin
      sat_coef = v[COEF_W-1:0];
    end
  endfunction

  logic [1:0]               mac_j_s;
  logic [1:0]               mac_ri_s;
  logic signed [COEF_W-1:0] mac_a_s;
  logic signed [ACF_W-1:0]  mac_r_s;
  logic signed [ACF_W-1:0]  r_m_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  acc_next_s;
  logic signed [ACC_W-1:0]  num_next_s;
  logic                     num_last_s;
  logic                     e_nonpos_s;
  logic                     r0_nonpos_s;

  // Serial MAC for the numerator: term j is a_j * R_(m-j).
  always_comb begin
    mac_j_s  = cnt_r[1:0] + 2'd1;
    mac_ri_s = m_r - mac_j_s;
    case (mac_j_s)
      2'd1:    mac_a_s = a1_r;
      2'd2:    mac_a_s = a2_r;
      2'd3:    mac_a_s = a3_r;
      default: mac_a_s = '0;
    endcase
    case (mac_ri_s)
      2'd0:    mac_r_s = r0_r;
      2'd1:    mac_r_s = r1_r;
      2'd2:    mac_r_s = r2_r;
      default: mac_r_s = r3_r;
    endcase
    case (m_r)
      2'd1:    r_m_s = r1_r;
      2'd2:    r_m_s = r2_r;
      2'd3:    r_m_s = r3_r;
      default: r_m_s = r0_r;
    endcase
    prod_s      = PROD_W'(mac_a_s) * PROD_W'(mac_r_s);
    acc_next_s  = acc_r + ACC_W'(prod_s);
    num_next_s  = ACC_W'(r_m_s) - (acc_next_s >>> FRAC_BITS);
    num_last_s  = (cnt_r[1:0] == (m_r - 2'd1));
    e_nonpos_s  = e_r[ACF_W-1] | (e_r == '0);
    r0_nonpos_s = r0_r[ACF_W-1] | (r0_r == '0);
  end

  logic [ACC_W-1:0]         mag_s;
  logic                     ovf_s;
  logic [REM_W-1:0]         rem2_s;
  logic                     rem_ge_s;
  logic [FRAC_BITS-1:0]     kmag_s;
  logic signed [COEF_W-1:0] kpos_s;
  logic signed [COEF_W-1:0] k_s;

  // Restoring divider on |N|; |N| >= E means |k| >= 1, so it saturates.
  always_comb begin
    if (num_r[ACC_W-1]) begin
      mag_s = -num_r;
    end else begin
      mag_s = num_r;
    end
    ovf_s    = (mag_s >= {{(ACC_W-ACF_W){1'b0}}, e_r});
    rem2_s   = {rem_r[REM_W-2:0], 1'b0};
    rem_ge_s = (rem2_s >= {2'b00, e_r});
    if (ovf_r) begin
      kmag_s = KMAX;
    end else begin
      kmag_s = q_r;
    end
    kpos_s = COEF_W'({1'b0, kmag_s});
    if (neg_r) begin
      k_s = -kpos_s;
    end else begin
      k_s = kpos_s;
    end
  end

  logic signed [COEF_W-1:0] part1_s;
  logic signed [KP_W-1:0]   kp1_s;
  logic signed [KP_W-1:0]   kp2_s;
  logic signed [COEF_W-1:0] upd1_s;
  logic signed [COEF_W-1:0] upd2_s;
  logic signed [EK_W-1:0]   ek_s;
  logic signed [EK_W-1:0]   e_full_s;
  logic signed [ACF_W-1:0]  e_next_s;

  // Coefficient step (old values only) and error update.
  always_comb begin
    if (m_r == 2'd3) begin
      part1_s = a2_r;
    end else begin
      part1_s = a1_r;
    end
    kp1_s    = KP_W'(k_r) * KP_W'(part1_s);
    kp2_s    = KP_W'(k_r) * KP_W'(a1_r);
    upd1_s   = sat_coef(KP_W'(a1_r) - (kp1_s >>> FRAC_BITS));
    upd2_s   = sat_coef(KP_W'(a2_r) - (kp2_s >>> FRAC_BITS));
    ek_s     = EK_W'(k_r) * EK_W'(num_r);
    e_full_s = EK_W'(e_r) - (ek_s >>> FRAC_BITS);
    e_next_s = e_full_s[ACF_W-1:0];
  end

  // Solver schedule, datapath registers and registered outputs.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_r <= IDLE;
      m_r     <= 2'd0;
      cnt_r   <= '0;
      r0_r    <= '0;
      r1_r    <= '0;
      r2_r    <= '0;
      r3_r    <= '0;
      a1_r    <= '0;
      a2_r    <= '0;
      a3_r    <= '0;
      e_r     <= '0;
      acc_r   <= '0;
      num_r   <= '0;
      k_r     <= '0;
      neg_r   <= 1'b0;
      ovf_r   <= 1'b0;
      rem_r   <= '0;
      q_r     <= '0;
      oBusy   <= 1'b0;
      oValid  <= 1'b0;
      oCoef1  <= '0;
      oCoef2  <= '0;
      oCoef3  <= '0;
      oError  <= '0;
    end else if (iEnable) begin
      case (state_r)
        IDLE: begin
          if (iValid) begin
            r0_r    <= iACF0;
            r1_r    <= iACF1;
            r2_r    <= iACF2;
            r3_r    <= iACF3;
            oBusy   <= 1'b1;
            state_r <= LOAD;
          end
        end
        LOAD: begin
          e_r     <= r0_r;
          a1_r    <= '0;
          a2_r    <= '0;
          a3_r    <= '0;
          m_r     <= 2'd1;
          cnt_r   <= '0;
          acc_r   <= '0;
          state_r <= r0_nonpos_s ? TERM : NUM;
        end
        NUM: begin
          if (num_last_s) begin
            num_r   <= num_next_s;
            acc_r   <= '0;
            cnt_r   <= '0;
            state_r <= e_nonpos_s ? TERM : DIV;
          end else begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + 1'b1;
          end
        end
        DIV: begin
          if (cnt_r == '0) begin
            neg_r <= num_r[ACC_W-1];
            ovf_r <= ovf_s;
            rem_r <= mag_s[REM_W-1:0];
            q_r   <= '0;
            cnt_r <= cnt_r + 1'b1;
          end else if (cnt_r == DIV_LAST) begin
            k_r     <= k_s;
            cnt_r   <= '0;
            state_r <= UPD;
          end else begin
            if (rem_ge_s) begin
              rem_r <= rem2_s - {2'b00, e_r};
              q_r   <= {q_r[FRAC_BITS-2:0], 1'b1};
            end else begin
              rem_r <= rem2_s;
              q_r   <= {q_r[FRAC_BITS-2:0], 1'b0};
            end
            cnt_r <= cnt_r + 1'b1;
          end
        end
        UPD: begin
          case (m_r)
            2'd1: a1_r <= k_r;
            2'd2: begin
              a2_r <= k_r;
              a1_r <= upd1_s;
            end
            2'd3: begin
              a3_r <= k_r;
              a1_r <= upd1_s;
              a2_r <= upd2_s;
            end
            default: a1_r <= a1_r;
          endcase
          state_r <= ERR;
        end
        ERR: begin
          e_r <= e_next_s;
          if (m_r == 2'd3) begin
            oCoef1  <= a1_r;
            oCoef2  <= a2_r;
            oCoef3  <= a3_r;
            oError  <= e_next_s;
            oValid  <= 1'b1;
            state_r <= DONE;
          end else begin
            m_r     <= m_r + 2'd1;
            state_r <= NUM;
          end
        end
        TERM: begin
          oCoef1  <= a1_r;
          oCoef2  <= a2_r;
          oCoef3  <= a3_r;
          oError  <= e_r;
          oValid  <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          oValid  <= 1'b0;
          oBusy   <= 1'b0;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lpc_levinson_durbin.md
Name: lpc_levinson_durbin

Overview:
- Downstream of the autocorrelation generator: takes one block's ACF lags R0..R3 and solves the order-3 Levinson-Durbin recursion.
- Produces fixed-point predictor coefficients and the final prediction error for the residual/quantisation stage.
- Sequential datapath: one shared restoring divider, fixed multi-cycle schedule, one result per accepted block.

Parameters:
- FRAC_BITS, 14, fractional bits of reflection and predictor coefficients.
- COEF_W, 18, signed width of output coefficients (integer range ±3 plus sign).
- ACF_W, 32, signed width of ACF inputs and error output.

Ports:
- iClock  in  1  clock, rising edge.
- iReset  in  1  asynchronous, active-low reset.
- iEnable  in  1  clock enable; when low, all state holds.
- iValid  in  1  one-cycle strobe; iACF0..3 valid.
- iACF0  in  ACF_W  R0 (signed).
- iACF1  in  ACF_W  R1.
- iACF2  in  ACF_W  R2.
- iACF3  in  ACF_W  R3.
- oBusy  out  1  high from accept until oValid, inclusive.
- oValid  out  1  one-cycle pulse; outputs valid and held until next oValid.
- oCoef1  out  COEF_W  a1 in Q(FRAC_BITS).
- oCoef2  out  COEF_W  a2.
- oCoef3  out  COEF_W  a3.
- oError  out  ACF_W  final prediction error E3 (or E at termination).

Behaviour:
- Reset (async, iReset=0): FSM to IDLE; oBusy=0, oValid=0, oCoef1..3=0, oError=0; internal R/a/E registers cleared. Reset mid-solve aborts with no oValid.
- iEnable=0: every register holds, including the divider and oValid; schedule resumes when iEnable returns high.
- Accept: in IDLE with iEnable=1 and iValid=1, R0..R3 latched; E0=R0. iValid while oBusy=1 is ignored.
- Prediction convention: x^[n] = sum a_j x[n-j]. For m=1..3:
  - Nm = Rm - sum_{j<m}(a_j*R_{m-j}) >>> FRAC_BITS, products at full width (ACF_W+COEF_W), arithmetic shift.
  - km = trunc_toward_zero((Nm << FRAC_BITS) / E_{m-1}).
  - a_m = km; a_j = a_j - (km*a_{m-j}) >>> FRAC_BITS for j<m, using old a values.
  - Em = E_{m-1} - (km*Nm) >>> FRAC_BITS.
- Saturation: km clamps to ±(2^FRAC_BITS - 1); a_j clamps to the COEF_W signed range.
- FSM: IDLE -> LOAD (1 cycle) -> per m: NUM (m cycles, one MAC/cycle) -> DIV (FRAC_BITS+2 cycles, sign fixup + 1 quotient bit/cycle + clamp) -> UPD (1 cycle, all a_j in parallel) -> ERR (1 cycle) -> next m or DONE -> IDLE.
- Latency: LOAD(1) + sum_{m=1..3}(m + FRAC_BITS + 4) = 61 cycles with default parameters. oValid is asserted in the cycle 61 clock edges after the accepting edge (enabled edges only).
- Degenerate: if E_{m-1} <= 0 when entering DIV, or R0 <= 0 at LOAD:
  - Terminate immediately; coefficients of order >= m are 0, earlier ones keep their values.
  - oError = E_{m-1}; oValid asserted on the next edge.
  - R0 <= 0 gives oValid 2 cycles after accept, all outputs 0 except oError=R0.
- Outputs update only on the oValid cycle; oBusy drops on the cycle after oValid.

Test Plan:
- R=[1000,500,250,125] -> oCoef1=8192, oCoef2=0, oCoef3=0, oError=750, oValid exactly 61 cycles after iValid.
- R=[1000,-500,250,-125] -> oCoef1=-8192, oCoef2=0, oCoef3=0, oError=750.
- R=[1000,0,-500,0] -> oCoef1=0, oCoef2=-8192, oCoef3=0, oError=750.
- R=[0,0,0,0] -> oValid 2 cycles after iValid, all coefficients 0, oError=0; R=[1000,0,0,0] -> all 0, oError=1000 at cycle 61.
- Second iValid 10 cycles into a solve -> ignored, a single oValid with the first block's result; iEnable held low for 5 cycles mid-DIV -> oValid at 66.
- iReset pulsed low at cycle 30 of a solve -> all outputs 0 immediately, no oValid; a fresh iValid afterwards completes normally in 61 cycles.
